reg_native_if_ext_fanout: RTL and testbench



---
 rtl/reg_native_if_pkg.sv | 31 +++
 rtl/reg_native_if_timeout_cnt.sv | 30 +++
 rtl/reg_native_if_ext_fanout.sv | 153 +++++++++++++++
 tb/tb_reg_native_if_ext_fanout.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_native_if_pkg.sv
// rtl/reg_native_if_pkg.sv - shared state type, constants and select helpers for reg_native_if fan-out
package reg_native_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned SEL_MAX = 32;
    localparam int unsigned IDX_W   = 5;

    localparam logic [31:0] DEFAULT_ERR_RD_DATA = 32'hDEAD_BEEF;

    function automatic logic is_onehot(input logic [SEL_MAX-1:0] v);
        return (v != '0) && ((v & (v - SEL_MAX'(1))) == '0);
    endfunction

    // Only meaningful for one-hot inputs; callers gate with is_onehot.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [SEL_MAX-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < SEL_MAX; i++) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/reg_native_if_timeout_cnt.sv
// rtl/reg_native_if_timeout_cnt.sv - wait-cycle counter with expiry flag; TIMEOUT_CYCLES=0 never expires
module reg_native_if_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LAST_CNT);

endmodule

// File: rtl/reg_native_if_ext_fanout.sv
// rtl/reg_native_if_ext_fanout.sv - registered one-outstanding forwarder from a native port to EXT_NUM IP ports
module reg_native_if_ext_fanout
    import reg_native_if_pkg::*;
#(
    parameter int unsigned EXT_NUM           = 4,
    parameter int unsigned BUS_DATA_WIDTH    = 32,
    parameter int unsigned BUS_ADDR_WIDTH    = 64,
    parameter int unsigned TIMEOUT_CYCLES    = 256,
    parameter int unsigned TIMEOUT_CNT_WIDTH = 16,
    parameter logic [BUS_DATA_WIDTH-1:0] ERR_RD_DATA = BUS_DATA_WIDTH'(DEFAULT_ERR_RD_DATA)
) (
    input  logic                              native_clk,
    input  logic                              native_rst,
    input  logic                              req_vld,
    input  logic [EXT_NUM-1:0]                sel,
    input  logic [BUS_ADDR_WIDTH-1:0]         addr,
    input  logic                              wr_en,
    input  logic                              rd_en,
    input  logic [BUS_DATA_WIDTH-1:0]         wr_data,
    output logic                              ack_vld,
    output logic                              err,
    output logic [BUS_DATA_WIDTH-1:0]         rd_data,
    output logic                              busy,
    output logic                              req_drop,
    output logic [EXT_NUM-1:0]                ext_req_vld,
    output logic [BUS_ADDR_WIDTH-1:0]         ext_addr,
    output logic                              ext_wr_en,
    output logic                              ext_rd_en,
    output logic [BUS_DATA_WIDTH-1:0]         ext_wr_data,
    input  logic [EXT_NUM-1:0]                ext_ack_vld,
    input  logic [EXT_NUM-1:0]                ext_err,
    input  logic [EXT_NUM*BUS_DATA_WIDTH-1:0] ext_rd_data
);

    state_e                    state;
    state_e                    state_nxt;
    logic [IDX_W-1:0]          sel_idx_q;
    logic                      sel_ok;
    logic                      ack_hit;
    logic                      ack_err;
    logic [BUS_DATA_WIDTH-1:0] ack_data;
    logic                      tmo_expired;
    logic                      tmo_hit;

    assign sel_ok = is_onehot(SEL_MAX'(sel));
    assign busy   = (state != IDLE);

    // Only the port that was issued the request can complete it.
    always_comb begin
        ack_hit  = 1'b0;
        ack_err  = 1'b0;
        ack_data = '0;
        for (int i = 0; i < EXT_NUM; i++) begin
            if (sel_idx_q == IDX_W'(i)) begin
                ack_hit  = ext_ack_vld[i];
                ack_err  = ext_err[i];
                ack_data = ext_rd_data[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            end
        end
    end

    reg_native_if_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (TIMEOUT_CNT_WIDTH)
    ) u_timeout_cnt (
        .clk     (native_clk),
        .rst     (native_rst),
        .clr     (state == IDLE),
        .en      ((state == WAIT) && !ack_hit),
        .expired (tmo_expired)
    );

    // An ack in the expiry cycle takes precedence over the timeout.
    assign tmo_hit = (state == WAIT) && !ack_hit && tmo_expired;

    always_ff @(posedge native_clk or posedge native_rst) begin
        if (native_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_vld) begin
                    state_nxt = sel_ok ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (ack_hit || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge native_clk or posedge native_rst) begin
        if (native_rst) begin
            sel_idx_q   <= '0;
            ack_vld     <= 1'b0;
            err         <= 1'b0;
            rd_data     <= '0;
            req_drop    <= 1'b0;
            ext_req_vld <= '0;
            ext_addr    <= '0;
            ext_wr_en   <= 1'b0;
            ext_rd_en   <= 1'b0;
            ext_wr_data <= '0;
        end else begin
            ack_vld     <= 1'b0;
            err         <= 1'b0;
            rd_data     <= '0;
            ext_req_vld <= '0;
            req_drop    <= req_vld && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (req_vld) begin
                        if (sel_ok) begin
                            sel_idx_q   <= onehot_to_idx(SEL_MAX'(sel));
                            ext_req_vld <= sel;
                            ext_addr    <= addr;
                            ext_wr_en   <= wr_en;
                            ext_rd_en   <= rd_en;
                            ext_wr_data <= wr_en ? wr_data : '0;
                        end else begin
                            ack_vld <= 1'b1;
                            err     <= 1'b1;
                            rd_data <= ERR_RD_DATA;
                        end
                    end
                end
                WAIT: begin
                    if (ack_hit) begin
                        ack_vld <= 1'b1;
                        err     <= ack_err;
                        rd_data <= ack_data;
                    end else if (tmo_hit) begin
                        ack_vld <= 1'b1;
                        err     <= 1'b1;
                        rd_data <= ERR_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_native_if_ext_fanout.sv
// tb/tb_reg_native_if_ext_fanout.sv - directed and randomized checks of reg_native_if_ext_fanout
module tb_reg_native_if_ext_fanout;

    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_vld;
    logic [3:0]   sel;
    logic [63:0]  addr;
    logic         wr_en;
    logic         rd_en;
    logic [31:0]  wr_data;
    logic         ack_vld;
    logic         err;
    logic [31:0]  rd_data;
    logic         busy;
    logic         req_drop;
    logic [3:0]   ext_req_vld;
    logic [63:0]  ext_addr;
    logic         ext_wr_en;
    logic         ext_rd_en;
    logic [31:0]  ext_wr_data;
    logic [3:0]   ext_ack_vld;
    logic [3:0]   ext_err;
    logic [127:0] ext_rd_data;

    int n_assert = 0;
    int n_fail   = 0;

    int          ev_cyc[$];
    int          ev_port[$];
    logic        ev_err[$];
    logic [31:0] ev_dat[$];

    always #5 clk = ~clk;

    reg_native_if_ext_fanout #(
        .EXT_NUM           (4),
        .BUS_DATA_WIDTH    (32),
        .BUS_ADDR_WIDTH    (64),
        .TIMEOUT_CYCLES    (TMO),
        .TIMEOUT_CNT_WIDTH (16),
        .ERR_RD_DATA       (ERR)
    ) dut (
        .native_clk  (clk),
        .native_rst  (rst),
        .req_vld     (req_vld),
        .sel         (sel),
        .addr        (addr),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .wr_data     (wr_data),
        .ack_vld     (ack_vld),
        .err         (err),
        .rd_data     (rd_data),
        .busy        (busy),
        .req_drop    (req_drop),
        .ext_req_vld (ext_req_vld),
        .ext_addr    (ext_addr),
        .ext_wr_en   (ext_wr_en),
        .ext_rd_en   (ext_rd_en),
        .ext_wr_data (ext_wr_data),
        .ext_ack_vld (ext_ack_vld),
        .ext_err     (ext_err),
        .ext_rd_data (ext_rd_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ack_vld"},     64'(ack_vld),     64'd0);
        check({tag, ".err"},         64'(err),         64'd0);
        check({tag, ".rd_data"},     64'(rd_data),     64'd0);
        check({tag, ".busy"},        64'(busy),        64'd0);
        check({tag, ".req_drop"},    64'(req_drop),    64'd0);
        check({tag, ".ext_req_vld"}, 64'(ext_req_vld), 64'd0);
        check({tag, ".ext_addr"},    ext_addr,         64'd0);
        check({tag, ".ext_wr_en"},   64'(ext_wr_en),   64'd0);
        check({tag, ".ext_rd_en"},   64'(ext_rd_en),   64'd0);
        check({tag, ".ext_wr_data"}, 64'(ext_wr_data), 64'd0);
    endtask

    task automatic add_ack(input int c, input int p, input logic e, input logic [31:0] d);
        ev_cyc.push_back(c);
        ev_port.push_back(p);
        ev_err.push_back(e);
        ev_dat.push_back(d);
    endtask

    // Cycle 0 carries the request; an event at cycle c is an ext ack driven during cycle c.
    task automatic run_txn(input string tag, input logic [3:0] t_sel, input logic t_wr, input logic t_rd,
                           input logic [63:0] t_addr, input logic [31:0] t_wdata, input int drop_cyc);
        int          rc;
        logic        re;
        logic [31:0] rdx;
        int          ncyc;
        logic        valid;
        valid = ($countones(t_sel) == 1);
        rc  = 0;
        re  = 1'b0;
        rdx = '0;
        if (!valid) begin
            rc = 1; re = 1'b1; rdx = ERR;
        end else begin
            for (int c = 1; c <= TMO && rc == 0; c++) begin
                for (int j = 0; j < ev_cyc.size(); j++) begin
                    if (rc == 0 && ev_cyc[j] == c && t_sel[ev_port[j]]) begin
                        rc = c + 1; re = ev_err[j]; rdx = ev_dat[j];
                    end
                end
            end
            if (rc == 0) begin
                rc = TMO + 1; re = 1'b1; rdx = ERR;
            end
        end
        ncyc = rc + 3;
        foreach (ev_cyc[j]) if (ev_cyc[j] + 2 > ncyc) ncyc = ev_cyc[j] + 2;
        if (drop_cyc + 2 > ncyc) ncyc = drop_cyc + 2;

        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            req_vld = (k == 0) || (k == drop_cyc);
            if (k == 0) begin
                sel = t_sel; addr = t_addr; wr_en = t_wr; rd_en = t_rd; wr_data = t_wdata;
            end else begin
                sel = 4'($urandom); addr = {$urandom, $urandom};
                wr_en = 1'($urandom); rd_en = 1'($urandom); wr_data = $urandom;
            end
            ext_ack_vld = '0;
            ext_err     = 4'($urandom);
            ext_rd_data = {$urandom, $urandom, $urandom, $urandom};
            foreach (ev_cyc[j]) begin
                if (ev_cyc[j] == k) begin
                    ext_ack_vld[ev_port[j]]          = 1'b1;
                    ext_err[ev_port[j]]              = ev_err[j];
                    ext_rd_data[ev_port[j]*32 +: 32] = ev_dat[j];
                end
            end
            @(negedge clk);
            check({tag, ".ack_vld"},  64'(ack_vld),  64'(k == rc));
            check({tag, ".err"},      64'(err),      64'((k == rc) ? re : 1'b0));
            check({tag, ".rd_data"},  64'(rd_data),  64'((k == rc) ? rdx : 32'd0));
            check({tag, ".busy"},     64'(busy),     64'(k >= 1 && k <= rc));
            check({tag, ".ext_req_vld"}, 64'(ext_req_vld), 64'((k == 1 && valid) ? t_sel : 4'd0));
            check({tag, ".req_drop"}, 64'(req_drop), 64'(drop_cyc >= 1 && k == drop_cyc + 1));
            if (valid && k >= 1 && k <= rc) begin
                check({tag, ".ext_addr"},    ext_addr,         t_addr);
                check({tag, ".ext_wr_en"},   64'(ext_wr_en),   64'(t_wr));
                check({tag, ".ext_rd_en"},   64'(ext_rd_en),   64'(t_rd));
                check({tag, ".ext_wr_data"}, 64'(ext_wr_data), 64'(t_wr ? t_wdata : 32'd0));
            end
        end
        req_vld = 1'b0;
        ext_ack_vld = '0;
        ev_cyc.delete(); ev_port.delete(); ev_err.delete(); ev_dat.delete();
    endtask

    initial begin
        logic [3:0] rs;
        int         rp;
        int         rdrop;

        rst = 1'b1; req_vld = 1'b0; sel = '0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        ext_ack_vld = '0; ext_err = '0; ext_rd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Read on port 2, ack four cycles after the request.
        add_ack(4, 2, 1'b0, 32'h1234_5678);
        run_txn("t1_read", 4'b0100, 1'b0, 1'b1, 64'h0000_0010_0000_0040, 32'hFFFF_FFFF, -1);

        // Write on port 0 with a combinational ack during the request pulse.
        add_ack(1, 0, 1'b0, 32'h0);
        run_txn("t2_write", 4'b0001, 1'b1, 1'b0, 64'h0000_0000_0000_0100, 32'hA5A5_A5A5, -1);

        run_txn("t3_sel_zero",  4'b0000, 1'b0, 1'b1, 64'h8, 32'h1, -1);
        run_txn("t3_sel_multi", 4'b0110, 1'b1, 1'b0, 64'hC, 32'h2, -1);

        // Timeout, then a late ack long after the error response.
        add_ack(20, 1, 1'b0, 32'h5555_5555);
        run_txn("t4_timeout", 4'b0010, 1'b0, 1'b1, 64'h20, 32'h0, -1);

        // Request while busy is dropped; ack on a foreign port is ignored.
        add_ack(3, 3, 1'b0, 32'h3333_3333);
        add_ack(5, 1, 1'b1, 32'h0BAD_F00D);
        run_txn("t5_drop", 4'b0010, 1'b0, 1'b1, 64'h30, 32'h0, 2);

        // Reset in the middle of a wait.
        @(posedge clk); #1;
        req_vld = 1'b1; sel = 4'b0001; wr_en = 1'b1; rd_en = 1'b0;
        addr = 64'hFEED_0000_0000_0004; wr_data = 32'h7777_7777;
        @(posedge clk); #1;
        req_vld = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_busy_before_rst", 64'(busy), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_all_zero("t6_async_rst");
        @(negedge clk);
        check_all_zero("t6_rst_held");
        @(posedge clk); #1;
        rst = 1'b0;
        add_ack(2, 0, 1'b0, 32'hCAFE_0001);
        run_txn("t6_after_rst", 4'b0001, 1'b0, 1'b1, 64'h44, 32'h0, -1);

        for (int n = 0; n < 20; n++) begin
            rp = $urandom_range(0, 3);
            rs = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << rp);
            if ($urandom_range(0, 3) != 0) begin
                add_ack($urandom_range(1, 10), rp, 1'($urandom), $urandom);
            end
            add_ack($urandom_range(1, 12), (rp + 1) % 4, 1'($urandom), $urandom);
            rdrop = ($urandom_range(0, 2) == 0) ? 1 : -1;
            run_txn("rand", rs, 1'($urandom), 1'($urandom), {$urandom, $urandom}, $urandom, rdrop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
